clk_div_ctrl: RTL and testbench

Runtime-programmable integer clock divider with controller. Owns the divide ratio, accepts new ratios over a valid/ready handshake, and applies them only at period boundaries, so clk_out never produces a runt pulse. Also provides a one-cycle tick per output period for logic that runs as a clock enable. It is the configuration and sequencing front end of the fixed divide-by-N blocks (div3_* family) used in ex9_div.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_core.sv | 52 +++++
 rtl/clk_div_ctrl.sv | 116 +++++++++++
 tb/tb_clk_div_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the programmable clock divider.
package clk_div_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StRun  = 2'd1;
   localparam state_t StPend = 2'd2;
   localparam state_t StStop = 2'd3;

   localparam int unsigned MIN_DIV = 2;

   // Number of high cycles in a period of n: ceil(n/2).
   function automatic int unsigned hi_cnt(input int unsigned n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter: produces registered clk_out/tick and flags the last cycle of a period.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         active,
   input  logic         run_next,
   input  logic [W-1:0] div,
   input  logic [W-1:0] div_next,
   output logic         boundary,
   output logic         clk_out,
   output logic         tick
);

   localparam logic [W-1:0] One = W'(1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         clk_out_q, clk_out_d;
   logic         tick_q, tick_d;

   // div >= 2 always, so div - 1 cannot underflow.
   assign boundary = active && (cnt_q == div - One);

   // Outputs are registered from the next-cycle count so they line up with cnt.
   always_comb begin
      cnt_d = '0;
      if (run_next && active && !boundary) begin
         cnt_d = cnt_q + One;
      end
      clk_out_d = run_next && (32'(cnt_d) < hi_cnt(32'(div_next)));
      tick_d    = run_next && (cnt_d == div_next - One);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: ratio handshake, FSM, and boundary-aligned ratio switching.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned W           = 8,
   parameter int unsigned DEFAULT_DIV = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         clk_out,
   output logic         tick,
   output logic         busy,
   output logic [W-1:0] cur_div
);

   state_t       state_q, state_d;
   logic [W-1:0] cur_div_q, cur_div_d;
   logic [W-1:0] pend_div_q, pend_div_d;
   logic         pend_vld_q, pend_vld_d;
   logic         cfg_err_q;
   logic         cfg_legal, cfg_take, cfg_load;
   logic         boundary;

   assign cfg_ready = (state_q != StPend);
   assign cfg_legal = (32'(cfg_div) >= MIN_DIV);
   assign cfg_take  = cfg_valid && cfg_ready;
   assign cfg_load  = cfg_take && cfg_legal;

   always_comb begin
      state_d    = state_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      pend_vld_d = pend_vld_q;
      case (state_q)
         StIdle: begin
            if (cfg_load) cur_div_d = cfg_div;
            if (en) state_d = StRun;
         end
         StRun: begin
            if (cfg_load && boundary) begin
               cur_div_d = cfg_div;
               state_d   = en ? StRun : StStop;
            end else if (cfg_load) begin
               pend_div_d = cfg_div;
               pend_vld_d = 1'b1;
               state_d    = StPend;
            end else if (!en) begin
               state_d = StStop;
            end
         end
         StPend: begin
            if (boundary) begin
               cur_div_d  = pend_div_q;
               pend_vld_d = 1'b0;
               state_d    = en ? StRun : StStop;
            end
         end
         StStop: begin
            if (cfg_load) begin
               pend_div_d = cfg_div;
               pend_vld_d = 1'b1;
            end
            if (boundary) begin
               if (cfg_load) cur_div_d = cfg_div;
               else if (pend_vld_q) cur_div_d = pend_div_q;
               pend_vld_d = 1'b0;
               state_d    = en ? StRun : StIdle;
            end else if (en) begin
               // A ratio latched while stopping still waits for the boundary.
               state_d = (cfg_load || pend_vld_q) ? StPend : StRun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cur_div_q  <= W'(DEFAULT_DIV);
         pend_div_q <= '0;
         pend_vld_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         pend_vld_q <= pend_vld_d;
         cfg_err_q  <= cfg_take && !cfg_legal;
      end
   end

   clk_div_core #(
      .W (W)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (state_q != StIdle),
      .run_next (state_d != StIdle),
      .div      (cur_div_q),
      .div_next (cur_div_d),
      .boundary (boundary),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   assign cfg_err = cfg_err_q;
   assign busy    = (state_q != StIdle);
   assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: period-level reference model feeds an expected queue.
module tb_clk_div_ctrl;

   localparam int unsigned W           = 8;
   localparam int unsigned DEFAULT_DIV = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic         cfg_ready, cfg_err, clk_out, tick, busy;
   logic [W-1:0] cur_div;

   clk_div_ctrl #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         ready;
      logic         err;
      logic         clk_out;
      logic         tick;
      logic         busy;
      logic [W-1:0] div;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: running flag, position in period, ratio, pending ratio (-1 = none),
   // and whether the run has been asked to stop.
   bit m_active, m_stop, m_err;
   int m_cnt, m_div, m_pend;

   function automatic bit m_ready();
      return !m_active || m_stop || (m_pend < 0);
   endfunction

   task automatic model_step(input bit r, input bit e, input bit v, input int d);
      bit   take, load, bnd, was_stop, was_pend;
      exp_t x;
      if (!r) begin
         m_active = 0; m_stop = 0; m_err = 0; m_cnt = 0; m_div = DEFAULT_DIV; m_pend = -1;
      end else begin
         take  = v && m_ready();
         load  = take && (d >= 2);
         m_err = take && (d < 2);
         if (!m_active) begin
            if (load) m_div = d;
            if (e) begin
               m_active = 1; m_stop = 0; m_cnt = 0;
            end
         end else begin
            bnd      = (m_cnt == m_div - 1);
            was_stop = m_stop;
            was_pend = !m_stop && (m_pend >= 0);
            if (bnd) begin
               m_cnt = 0;
               if (load) begin
                  m_div = d; m_pend = -1;
               end else if (m_pend >= 0) begin
                  m_div = m_pend; m_pend = -1;
               end
               if (was_stop && !e) m_active = 0;
               m_stop = m_active && !e;
            end else begin
               m_cnt++;
               if (load) m_pend = d;
               if (was_stop) m_stop = !e;
               else if (!was_pend && !load) m_stop = !e;
            end
         end
      end
      x.ready   = m_ready();
      x.err     = m_err;
      x.clk_out = m_active && (m_cnt < m_div - m_div / 2);
      x.tick    = m_active && (m_cnt == m_div - 1);
      x.busy    = m_active;
      x.div     = m_div[W-1:0];
      exp_q.push_back(x);
   endtask

   task automatic step(input bit r, input bit e, input bit v, input logic [W-1:0] d);
      @(negedge clk);
      rst_n     = r;
      en        = e;
      cfg_valid = v;
      cfg_div   = d;
      model_step(r, e, v, int'(d));
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are presented every cycle, compared just after the rising edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         check("cfg_ready", 32'(cfg_ready), 32'(x.ready));
         check("cfg_err", 32'(cfg_err), 32'(x.err));
         check("clk_out", 32'(clk_out), 32'(x.clk_out));
         check("tick", 32'(tick), 32'(x.tick));
         check("busy", 32'(busy), 32'(x.busy));
         check("cur_div", 32'(cur_div), 32'(x.div));
      end
   end

   initial begin
      bit e;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (9) step(1, 1, 0, 0);
      step(1, 1, 1, 8'd4);
      repeat (10) step(1, 1, 0, 0);
      step(1, 1, 1, 8'd1);
      repeat (6) step(1, 1, 0, 0);
      step(1, 1, 1, 8'd5);
      repeat (12) step(1, 1, 0, 0);
      repeat (12) step(1, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      repeat (8) step(1, 1, 0, 0);
      step(1, 1, 1, 8'd4);
      repeat (9) step(1, 1, 0, 0);
      step(1, 1, 1, 8'd255);
      repeat (300) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      repeat (4) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 0, 1, 8'd0);
      step(1, 0, 1, 8'd7);
      repeat (10) step(1, 1, 0, 0);

      e = 1;
      for (int i = 0; i < 6000; i++) begin
         logic [W-1:0] d;
         bit           v, r;
         if ($urandom_range(15) == 0) e = !e;
         v = ($urandom_range(9) == 0);
         case ($urandom_range(15))
            0, 1, 2, 3: d = W'($urandom_range(1));
            4:          d = W'($urandom_range(255, 100));
            default:    d = W'($urandom_range(9, 2));
         endcase
         r = ($urandom_range(399) != 0);
         step(r, e, v, d);
      end

      @(posedge clk);
      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
